// File: rtl/handshake_requester.sv
// handshake_requester
//   Requester-side master sitting upstream of a request/grant arbiter. A start
//   command raises req. Once gnt is seen, len words are moved from a local
//   valid/ready source onto a shared valid/ack bus through a one-word hold
//   register. After the burst req drops for one cycle while done pulses.
//   Losing gnt mid-burst parks the requester back in REQ, keeping the held word
//   and the remaining count. Waiting too long for gnt abandons the command.
//
// Ports
//   clk       in   system clock, all state on rising edge
//   rst       in   synchronous active-high reset
//   start     in   command strobe, honoured only in IDLE
//   len       in   burst length, captured with start
//   srcValid  in   source word available
//   srcData   in   source word
//   srcReady  out  source word accepted this cycle (combinational)
//   req       out  request to arbiter (registered)
//   gnt       in   grant from arbiter
//   busValid  out  bus word valid (registered)
//   busData   out  bus word (registered, doubles as the hold register)
//   busAck    in   bus target accepted word
//   busy      out  high in any state except IDLE
//   done      out  one-cycle pulse at burst completion or zero-length command
//   timeout   out  one-cycle pulse when the grant wait expires
module handshake_requester #(
  parameter int DATA_W      = 8,
  parameter int LEN_W       = 4,
  parameter int GNT_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              srcValid,
  input  logic [DATA_W-1:0] srcData,
  output logic              srcReady,
  output logic              req,
  input  logic              gnt,
  output logic              busValid,
  output logic [DATA_W-1:0] busData,
  input  logic              busAck,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  localparam int WAIT_W = (GNT_TIMEOUT < 2) ? 1 : $clog2(GNT_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (GNT_TIMEOUT == 0) ? {WAIT_W{1'b0}} : WAIT_W'(GNT_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_XFER,
    S_REL
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;

  logic [LEN_W-1:0]    r_remaining;
  logic [LEN_W-1:0]    w_remaining_nx;
  logic [WAIT_W-1:0]   r_waitCnt;
  logic [WAIT_W-1:0]   w_waitCnt_nx;
  logic                r_holdFull;
  logic                w_holdFull_nx;
  logic [DATA_W-1:0]   r_busData;
  logic                r_busValid;
  logic                r_req;
  logic                r_done;
  logic                r_timeout;

  logic                w_srcReady;
  logic                w_load;
  logic                w_ack;
  logic                w_done_nx;
  logic                w_timeout_nx;

  assign w_srcReady = (r_state == S_XFER) && gnt && !r_holdFull;
  // busValid is only ever high in XFER with the hold register full, so an ack
  // qualified by it is already restricted to a live word.
  assign w_ack      = busAck && r_busValid;

  always_comb begin
    w_state_nx     = r_state;
    w_remaining_nx = r_remaining;
    w_waitCnt_nx   = r_waitCnt;
    w_holdFull_nx  = r_holdFull;
    w_load         = 1'b0;
    w_done_nx      = 1'b0;
    w_timeout_nx   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            w_remaining_nx = len;
            w_waitCnt_nx   = '0;
            w_state_nx     = S_REQ;
          end else begin
            w_done_nx = 1'b1;
          end
        end
      end

      S_REQ: begin
        if (gnt) begin
          w_state_nx = S_XFER;
        end else if ((GNT_TIMEOUT != 0) && (r_waitCnt == WAIT_LAST)) begin
          w_timeout_nx   = 1'b1;
          w_remaining_nx = '0;
          w_holdFull_nx  = 1'b0;
          w_state_nx     = S_IDLE;
        end else if (r_waitCnt != '1) begin
          w_waitCnt_nx = r_waitCnt + WAIT_W'(1);
        end
      end

      S_XFER: begin
        if (w_srcReady && srcValid) begin
          w_load        = 1'b1;
          w_holdFull_nx = 1'b1;
        end
        // An ack arriving together with a grant drop still retires the word;
        // the last word wins over preemption and heads straight to REL.
        if (w_ack) begin
          w_holdFull_nx = 1'b0;
          if (r_remaining != '0) begin
            w_remaining_nx = r_remaining - LEN_W'(1);
          end
        end
        if (w_ack && (r_remaining == LEN_W'(1))) begin
          w_state_nx = S_REL;
          w_done_nx  = 1'b1;
        end else if (!gnt) begin
          w_waitCnt_nx = '0;
          w_state_nx   = S_REQ;
        end
      end

      S_REL: begin
        w_state_nx = S_IDLE;
      end

      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_remaining <= '0;
      r_waitCnt   <= '0;
      r_holdFull  <= 1'b0;
      r_busData   <= '0;
      r_busValid  <= 1'b0;
      r_req       <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_remaining <= w_remaining_nx;
      r_waitCnt   <= w_waitCnt_nx;
      r_holdFull  <= w_holdFull_nx;
      if (w_load) begin
        r_busData <= srcData;
      end
      r_busValid  <= w_holdFull_nx && (w_state_nx == S_XFER);
      r_req       <= (w_state_nx == S_REQ) || (w_state_nx == S_XFER);
      r_done      <= w_done_nx;
      r_timeout   <= w_timeout_nx;
    end
  end

  assign srcReady = w_srcReady;
  assign req      = r_req;
  assign busValid = r_busValid;
  assign busData  = r_busData;
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign timeout  = r_timeout;

endmodule

// File: tb/tb_handshake_requester.sv
// Directed bench for handshake_requester (GNT_TIMEOUT overridden to 4).
module tb_handshake_requester;

  localparam int DATA_W = 8;
  localparam int LEN_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              srcValid;
  logic [DATA_W-1:0] srcData;
  logic              srcReady;
  logic              req;
  logic              gnt;
  logic              busValid;
  logic [DATA_W-1:0] busData;
  logic              busAck;
  logic              busy;
  logic              done;
  logic              timeout;

  handshake_requester #(
    .DATA_W      (DATA_W),
    .LEN_W       (LEN_W),
    .GNT_TIMEOUT (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .srcValid (srcValid),
    .srcData  (srcData),
    .srcReady (srcReady),
    .req      (req),
    .gnt      (gnt),
    .busValid (busValid),
    .busData  (busData),
    .busAck   (busAck),
    .busy     (busy),
    .done     (done),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] src_mem [0:7];
  int         src_idx;

  // Observations recorded by run_burst
  logic [7:0] log_d [0:15];
  int         acks, done_cyc, tmo_cyc, req_cnt, sr_cnt, sr_while_bv;
  int         unstable, bv_gnt_low, bv_rise;
  logic       req_in_done, tmo_req, req_at1, finished;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_src(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
    src_mem[0] = a; src_mem[1] = b; src_mem[2] = c; src_mem[3] = d;
    for (int i = 4; i < 8; i++) src_mem[i] = 8'h00;
    src_idx = 0;
    srcData = a;
  endtask

  // Drives gnt/busAck cycle by cycle and records what the DUT did.
  task automatic run_burst(input int ack_delay, input int drop_word, input int drop_len,
                           input int gnt_on, input bit hold_start, input bit spurious,
                           input bit stop_bv, input int max_cyc);
    int cyc, vcnt, drop_left;
    bit dropped, consumed, acked, prev_bv, prev_gnt;
    logic [7:0] prev_bd;
    cyc = 0; vcnt = 0; drop_left = 0; dropped = 1'b0;
    acks = 0; done_cyc = -1; tmo_cyc = -1; req_cnt = 0; sr_cnt = 0; sr_while_bv = 0;
    unstable = 0; bv_gnt_low = 0; bv_rise = 0;
    req_in_done = 1'b0; tmo_req = 1'b0; req_at1 = 1'b0; finished = 1'b0;
    while (!finished && cyc < max_cyc) begin
      if (drop_word >= 0 && !dropped && busValid && acks == drop_word) begin
        drop_left = drop_len;
        dropped   = 1'b1;
      end
      gnt    = (cyc >= gnt_on) && (drop_left == 0);
      busAck = busValid ? ((vcnt > ack_delay) && (drop_left == 0)) : spurious;
      #1;
      if (srcReady) sr_cnt++;
      if (srcReady && busValid) sr_while_bv++;
      consumed = srcReady && srcValid;
      acked    = busAck && busValid;
      prev_bv  = busValid;
      prev_bd  = busData;
      prev_gnt = gnt;
      @(posedge clk);
      #1;
      cyc++;
      if (!hold_start) start = 1'b0;
      if (drop_left > 0) drop_left--;
      if (consumed && src_idx < 7) begin
        src_idx++;
        srcData = src_mem[src_idx];
      end
      if (acked && acks < 16) begin
        log_d[acks] = prev_bd;
        acks++;
      end
      if (busValid && !prev_bv) bv_rise++;
      vcnt = !busValid ? 0 : ((prev_bv && !acked) ? vcnt + 1 : 1);
      if (prev_bv && busValid && !acked && busData !== prev_bd) unstable++;
      if (!prev_gnt && busValid) bv_gnt_low++;
      if (req) req_cnt++;
      if (cyc == 1) req_at1 = req;
      if (done) begin done_cyc = cyc; req_in_done = req; finished = 1'b1; end
      if (timeout) begin tmo_cyc = cyc; tmo_req = req; finished = 1'b1; end
      if (stop_bv && busValid) finished = 1'b1;
    end
    busAck = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({req, busValid, busData, done, timeout, busy, srcReady} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b bv=%b bd=%h done=%b tmo=%b busy=%b sr=%b expected all 0",
               req, busValid, busData, done, timeout, busy, srcReady);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    load_src(8'hA1, 8'hA2, 8'hA3, 8'h00);
    start = 1'b1; len = 4'd3;
    run_burst(1, -1, 0, 0, 1'b0, 1'b0, 1'b0, 40);
    checks++;
    if (req_at1 !== 1'b1) begin errors++; $display("FAIL basic_req_cycle1: got %b expected 1", req_at1); end
    checks++;
    if (done_cyc !== 11) begin errors++; $display("FAIL basic_done_cyc: got %0d expected 11", done_cyc); end
    checks++;
    if (acks !== 3) begin errors++; $display("FAIL basic_acks: got %0d expected 3", acks); end
    checks++;
    if ({log_d[0], log_d[1], log_d[2]} !== 24'hA1A2A3) begin
      errors++;
      $display("FAIL basic_data: got %h %h %h expected a1 a2 a3", log_d[0], log_d[1], log_d[2]);
    end
    checks++;
    if (req_in_done !== 1'b0) begin errors++; $display("FAIL basic_req_in_done: got %b expected 0", req_in_done); end
    tick();
    checks++;
    if ({busy, done, req} !== 3'b000) begin
      errors++; $display("FAIL basic_after_rel: got busy=%b done=%b req=%b expected 000", busy, done, req);
    end
  endtask

  task automatic test_timeout();
    load_src(8'hB1, 8'hB2, 8'h00, 8'h00);
    start = 1'b1; len = 4'd2;
    run_burst(1, -1, 0, 1000, 1'b0, 1'b0, 1'b0, 30);
    checks++;
    if (tmo_cyc !== 5) begin errors++; $display("FAIL tmo_cycle: got %0d expected 5", tmo_cyc); end
    checks++;
    if (tmo_req !== 1'b0 || req_cnt !== 4) begin
      errors++; $display("FAIL tmo_req: got req=%b req_cycles=%0d expected 0 and 4", tmo_req, req_cnt);
    end
    checks++;
    if (sr_cnt !== 0) begin errors++; $display("FAIL tmo_srcready: got %0d cycles expected 0", sr_cnt); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy: got %b expected 0", busy); end
    tick();
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("FAIL tmo_pulse_width: got %b expected 0", timeout); end

    load_src(8'hC1, 8'hC2, 8'h00, 8'h00);
    start = 1'b1; len = 4'd2;
    run_burst(1, -1, 0, 3, 1'b0, 1'b0, 1'b0, 30);
    checks++;
    if (tmo_cyc !== -1 || done_cyc !== 10) begin
      errors++; $display("FAIL late_gnt: got tmo_cyc=%0d done_cyc=%0d expected -1 and 10", tmo_cyc, done_cyc);
    end
    checks++;
    if (acks !== 2 || {log_d[0], log_d[1]} !== 16'hC1C2) begin
      errors++; $display("FAIL late_gnt_data: got %0d acks %h %h expected 2 c1 c2", acks, log_d[0], log_d[1]);
    end
    tick();
  endtask

  task automatic test_preempt();
    load_src(8'h11, 8'h22, 8'h33, 8'h44);
    start = 1'b1; len = 4'd4;
    run_burst(1, 1, 3, 0, 1'b0, 1'b0, 1'b0, 60);
    checks++;
    if (bv_gnt_low !== 0) begin errors++; $display("FAIL preempt_bv_low: got %0d cycles expected 0", bv_gnt_low); end
    checks++;
    if (bv_rise !== 5) begin errors++; $display("FAIL preempt_represent: got %0d bv rises expected 5", bv_rise); end
    checks++;
    if (acks !== 4 || {log_d[0], log_d[1], log_d[2], log_d[3]} !== 32'h11223344) begin
      errors++;
      $display("FAIL preempt_data: got %0d acks %h %h %h %h expected 4 11 22 33 44",
               acks, log_d[0], log_d[1], log_d[2], log_d[3]);
    end
    checks++;
    if (done_cyc < 0 || tmo_cyc !== -1) begin
      errors++; $display("FAIL preempt_done: got done_cyc=%0d tmo_cyc=%0d expected done and no timeout", done_cyc, tmo_cyc);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL preempt_single_done: got done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_backpressure();
    load_src(8'hD1, 8'hD2, 8'h00, 8'h00);
    start = 1'b1; len = 4'd2;
    run_burst(5, -1, 0, 0, 1'b0, 1'b0, 1'b0, 60);
    checks++;
    if (unstable !== 0) begin errors++; $display("FAIL bp_stable: got %0d changes expected 0", unstable); end
    checks++;
    if (sr_while_bv !== 0) begin errors++; $display("FAIL bp_srcready: got %0d cycles expected 0", sr_while_bv); end
    checks++;
    if (done_cyc !== 16 || {log_d[0], log_d[1]} !== 16'hD1D2) begin
      errors++; $display("FAIL bp_done: got cyc=%0d data %h %h expected 16 d1 d2", done_cyc, log_d[0], log_d[1]);
    end
    tick();
  endtask

  task automatic test_edge_cmds();
    start = 1'b1; len = 4'd0;
    tick();
    checks++;
    if ({done, req, busy} !== 3'b100) begin
      errors++; $display("FAIL zero_len: got done=%b req=%b busy=%b expected 1 0 0", done, req, busy);
    end
    start = 1'b0;
    tick();
    checks++;
    if ({done, req} !== 2'b00) begin errors++; $display("FAIL zero_len_pulse: got done=%b req=%b expected 0 0", done, req); end

    // start held through the whole burst and busAck raised whenever busValid is low
    load_src(8'hE1, 8'hE2, 8'hE3, 8'hE4);
    start = 1'b1; len = 4'd2;
    run_burst(1, -1, 0, 0, 1'b1, 1'b1, 1'b0, 40);
    checks++;
    if (done_cyc !== 8 || acks !== 2) begin
      errors++; $display("FAIL start_in_xfer: got done_cyc=%0d acks=%0d expected 8 and 2", done_cyc, acks);
    end
    checks++;
    if ({log_d[0], log_d[1]} !== 16'hE1E2) begin
      errors++; $display("FAIL spurious_ack_data: got %h %h expected e1 e2", log_d[0], log_d[1]);
    end
    tick();
    start = 1'b0;
    checks++;
    if ({busy, req, done} !== 3'b000) begin
      errors++; $display("FAIL start_in_rel: got busy=%b req=%b done=%b expected 000", busy, req, done);
    end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    load_src(8'h66, 8'h77, 8'h88, 8'h00);
    start = 1'b1; len = 4'd3;
    run_burst(100, -1, 0, 0, 1'b0, 1'b0, 1'b1, 20);
    checks++;
    if (busValid !== 1'b1) begin errors++; $display("FAIL rstmid_pending: got bv=%b expected 1", busValid); end
    rst = 1'b1;
    tick();
    checks++;
    if ({req, busValid, busData, done, timeout, busy, srcReady} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: got req=%b bv=%b bd=%h done=%b tmo=%b busy=%b sr=%b expected all 0",
               req, busValid, busData, done, timeout, busy, srcReady);
    end
    rst = 1'b0;
    load_src(8'h5A, 8'h00, 8'h00, 8'h00);
    start = 1'b1; len = 4'd1;
    run_burst(1, -1, 0, 0, 1'b0, 1'b0, 1'b0, 30);
    checks++;
    if (done_cyc !== 5 || acks !== 1 || log_d[0] !== 8'h5A) begin
      errors++;
      $display("FAIL rstmid_restart: got done_cyc=%0d acks=%0d data=%h expected 5 1 5a", done_cyc, acks, log_d[0]);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; srcValid = 1'b1; srcData = '0;
    gnt = 1'b0; busAck = 1'b0;
    test_reset();
    test_basic();
    test_timeout();
    test_preempt();
    test_backpressure();
    test_edge_cmds();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/handshake_requester.md
Name: handshake_requester

Overview:
- Requester-side master that sits directly upstream of the two-input request/grant arbiter. One instance drives each arbiter request line.
- On a start command it raises req and waits for gnt. Once granted, it moves a burst of len words from a local source (valid/ready) onto the shared bus (valid/ack).
- After the burst it releases req for one cycle and pulses done.

Parameters:
- DATA_W, 8, data word width.
- LEN_W, 4, burst-length field width; max burst 2^LEN_W-1 words.
- GNT_TIMEOUT, 255, cycles to wait for gnt in REQ before abandoning; 0 = wait forever.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command strobe, sampled only in IDLE.
- len  in  LEN_W  burst length, captured with start.
- srcValid  in  1  source word available.
- srcData  in  DATA_W  source word.
- srcReady  out  1  word accepted this cycle (combinational).
- req  out  1  request to arbiter.
- gnt  in  1  grant from arbiter.
- busValid  out  1  bus word valid.
- busData  out  DATA_W  bus word.
- busAck  in  1  bus target accepted word.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at burst completion or zero-length command.
- timeout  out  1  one-cycle pulse when grant wait expires.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: state=IDLE, remaining=0, waitCnt=0, hold register empty, busData=0. req, busValid, busy, done and timeout are all 0. Reset mid-burst takes effect at the next edge and discards any pending word.
- Registered outputs: req, busValid, busData, done, timeout. srcReady = (state==XFER) && gnt && !holdFull.
- IDLE:
  - start && len!=0: remaining<=len, waitCnt<=0, go to REQ.
  - start && len==0: done pulses next cycle; stay in IDLE.
  - start outside IDLE is ignored.
- REQ:
  - req=1.
  - gnt==1 sampled: go to XFER.
  - Otherwise waitCnt increments. If GNT_TIMEOUT!=0 and waitCnt==GNT_TIMEOUT-1 with gnt low: timeout pulses, req drops the same cycle as the pulse, go to IDLE. remaining is discarded.
- XFER:
  - req=1.
  - srcValid && srcReady at an edge: word loaded into hold register (holdFull=1).
  - busValid = holdFull && (state==XFER), registered.
  - busData stays stable while busValid=1.
  - busAck with busValid=1: holdFull<=0, remaining<=remaining-1. If remaining==1, go to REL.
  - busAck with busValid=0: ignored.
  - Throughput: at most one word per 2 cycles.
- gnt loss in XFER (preemption): return to REQ with remaining and hold register kept, and busValid<=0. On re-grant, the same held word is re-presented before any new source word is taken. waitCnt restarts at 0.
- REL: req=0 and done=1 for exactly one cycle, then go to IDLE. Guarantees at least one req-low cycle between back-to-back bursts. start in REL is ignored.
- Simultaneous gnt drop and busAck in the same cycle: the ack counts (word retired), then go to REQ, or to REL if it was the last word.
- Counter widths: remaining is LEN_W bits and never underflows. waitCnt is sized to hold GNT_TIMEOUT and saturates when GNT_TIMEOUT=0.

Test Plan:
- Basic burst: rst 2 cycles, start len=3, gnt tied 1, srcValid=1 with data 0xA1,0xA2,0xA3, busAck 1 cycle after each busValid. Required: req high from cycle 1; busData sequence A1,A2,A3; done one pulse; req low in the done cycle; busy falls after REL.
- Grant wait / timeout: GNT_TIMEOUT=4, start len=2, gnt=0. Required: timeout pulse after 4 REQ cycles, req low, no srcReady ever asserted. Repeat with gnt raised at REQ cycle 3: burst completes normally.
- Preemption: len=4, drop gnt for 3 cycles while word 2 (0x22) is held. Required: busValid=0 during loss; after re-grant busData=0x22 again; exactly 4 acks total; done once.
- Backpressure: busAck delayed 5 cycles per word. Required: busValid and busData stable until ack, srcReady=0 while holdFull.
- Edge commands: start len=0 → done next cycle, req never high. start during XFER ignored. busAck with busValid=0 leaves remaining unchanged.
- Reset mid-burst: assert rst during XFER with a word pending. Required: next cycle all outputs 0 and state IDLE; a new start len=1 then completes cleanly.
